// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared types for the firebird7_in_gate1 IJTAG data-mux control TDR.
// Holds the per-edge op decode enum and the chain length helper.
package firebird7_in_gate1_tessent_tdr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    UPDATE  = 2'd3
  } tdr_op_e;

  // One select bit sits above the data word.
  function automatic int chain_len(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_shift_cell.sv
// One capture/shift bit of the TDR chain.
// Capture wins over shift; the cell holds when neither is enabled.
module firebird7_in_gate1_tessent_tdr_shift_cell (
  input  logic clk,
  input  logic rst,
  input  logic cap_en,
  input  logic shift_en,
  input  logic cap_d,
  input  logic shift_d,
  output logic q
);

  logic bit_d;
  logic bit_q;

  always_comb begin
    bit_d = bit_q;
    if (cap_en) begin
      bit_d = cap_d;
    end else if (shift_en) begin
      bit_d = shift_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q = bit_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_dmux_ctl.sv
// IJTAG TDR driving select and data of the firebird7_in_gate1 data mux.
// Captures {select, functional data}, shifts LSB-first, applies on update.
module firebird7_in_gate1_tessent_tdr_dmux_ctl
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int               WIDTH        = 3,
  parameter logic             RESET_SELECT = 1'b0,
  parameter logic [WIDTH-1:0] RESET_DATA   = '0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out
);

  localparam int L = chain_len(WIDTH);

  tdr_op_e        sr_op;
  logic           upd_en;
  logic           cap_en;
  logic           shift_en;
  logic [L-1:0]   shift_reg;
  logic [L-1:0]   cap_vec;
  logic [L-1:0]   shift_vec;

  logic             upd_sel_d;
  logic             upd_sel_q;
  logic [WIDTH-1:0] upd_data_d;
  logic [WIDTH-1:0] upd_data_q;

  always_comb begin
    sr_op = IDLE;
    if (ijtag_sel && ijtag_ce) begin
      sr_op = CAPTURE;
    end else if (ijtag_sel && ijtag_se) begin
      sr_op = SHIFT;
    end
  end

  assign cap_en    = (sr_op == CAPTURE);
  assign shift_en  = (sr_op == SHIFT);
  assign upd_en    = ijtag_sel && ijtag_ue;
  assign cap_vec   = {upd_sel_q, functional_data_in};
  assign shift_vec = {ijtag_si, shift_reg[L-1:1]};

  for (genvar i = 0; i < L; i++) begin : g_cell
    firebird7_in_gate1_tessent_tdr_shift_cell u_cell (
      .clk      (ijtag_tck),
      .rst      (ijtag_reset),
      .cap_en   (cap_en),
      .shift_en (shift_en),
      .cap_d    (cap_vec[i]),
      .shift_d  (shift_vec[i]),
      .q        (shift_reg[i])
    );
  end

  // Update reads the pre-edge chain, so capture/shift on the same edge is fine.
  always_comb begin
    upd_sel_d  = upd_sel_q;
    upd_data_d = upd_data_q;
    if (upd_en) begin
      upd_sel_d  = shift_reg[WIDTH];
      upd_data_d = shift_reg[WIDTH-1:0];
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      upd_sel_q  <= RESET_SELECT;
      upd_data_q <= RESET_DATA;
    end else begin
      upd_sel_q  <= upd_sel_d;
      upd_data_q <= upd_data_d;
    end
  end

  assign ijtag_so       = shift_reg[0];
  assign ijtag_select   = upd_sel_q;
  assign ijtag_data_out = upd_data_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_dmux_ctl.sv
// Directed bench for the firebird7_in_gate1 data-mux control TDR.
// Hand-computed vectors covering reset, capture, shift, update and priority.
module tb_firebird7_in_gate1_tessent_tdr_dmux_ctl;
  import firebird7_in_gate1_tessent_tdr_pkg::*;

  localparam int W = 3;
  localparam int L = chain_len(W);

  logic         clk = 1'b0;
  logic         rst;
  logic         sel, ce, se, ue, si;
  logic         so;
  logic [W-1:0] fdi;
  logic         osel;
  logic [W-1:0] odata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sv_sel, sv_data, sv_so;

  always #5 clk = ~clk;

  firebird7_in_gate1_tessent_tdr_dmux_ctl #(
    .WIDTH        (W),
    .RESET_SELECT (1'b0),
    .RESET_DATA   ('0)
  ) dut (
    .ijtag_tck          (clk),
    .ijtag_reset        (rst),
    .ijtag_sel          (sel),
    .ijtag_ce           (ce),
    .ijtag_se           (se),
    .ijtag_ue           (ue),
    .ijtag_si           (si),
    .ijtag_so           (so),
    .functional_data_in (fdi),
    .ijtag_select       (osel),
    .ijtag_data_out     (odata)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rst = 1'b0; sel = 1'b0; ce = 1'b0;
    se  = 1'b0; ue  = 1'b0; si = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    sel = 1'b1; se = 1'b1; ce = 1'b0; ue = 1'b0; si = b;
    tick();
    idle();
  endtask

  task automatic update;
    sel = 1'b1; ue = 1'b1; ce = 1'b0; se = 1'b0;
    tick();
    idle();
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] exp_so;
    idle();
    fdi = '0;
    #2;

    // Reset with random other inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = 1'($urandom); ce = 1'($urandom); se = 1'($urandom);
      ue  = 1'($urandom); si = 1'($urandom); fdi = 3'($urandom);
      tick();
    end
    idle();
    chk("rst_sel", 8'(osel), 8'h0);
    chk("rst_data", 8'(odata), 8'h0);
    chk("rst_so", 8'(so), 8'h0);

    // Capture 101 with upd_sel=0, then shift out
    fdi = 3'b101;
    sel = 1'b1; ce = 1'b1;
    tick();
    idle();
    exp_so = 4'b0101;
    for (int i = 0; i < L; i++) begin
      chk($sformatf("cap_so%0d", i), 8'(so), 8'(exp_so[i]));
      shift_bit(1'b0);
    end

    // Shift 1,1,0,1 then update; outputs frozen during shift
    pat = 4'b1011;
    for (int i = 0; i < L; i++) begin
      shift_bit(pat[i]);
      chk($sformatf("shf_sel%0d", i), 8'(osel), 8'h0);
      chk($sformatf("shf_dat%0d", i), 8'(odata), 8'h0);
    end
    update();
    chk("upd_sel", 8'(osel), 8'h1);
    chk("upd_data", 8'(odata), 8'h3);

    // Deselected: nothing moves
    sv_sel = 8'(osel); sv_data = 8'(odata); sv_so = 8'(so);
    chk("pre_desel_so", sv_so, 8'h1);
    fdi = 3'b010;
    for (int i = 0; i < L; i++) begin
      sel = 1'b0; se = 1'b1; ce = 1'(i == 0); si = ~pat[i];
      tick();
    end
    sel = 1'b0; ue = 1'b1;
    tick();
    idle();
    chk("desel_sel", 8'(osel), sv_sel);
    chk("desel_data", 8'(odata), sv_data);
    chk("desel_so", 8'(so), sv_so);

    // Load 1010, then ce+se+ue together
    pat = 4'b1010;
    for (int i = 0; i < L; i++) shift_bit(pat[i]);
    fdi = 3'b111;
    sel = 1'b1; ce = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b0;
    tick();
    idle();
    chk("sim_sel", 8'(osel), 8'h1);
    chk("sim_data", 8'(odata), 8'h2);
    for (int i = 0; i < L; i++) begin
      chk($sformatf("sim_so%0d", i), 8'(so), 8'h1);
      shift_bit(1'b0);
    end

    // Reset mid-shift, then update loads zeroed chain
    shift_bit(1'b1);
    shift_bit(1'b1);
    rst = 1'b1;
    tick();
    idle();
    chk("mid_rst_so", 8'(so), 8'h0);
    update();
    chk("mid_upd_sel", 8'(osel), 8'h0);
    chk("mid_upd_data", 8'(odata), 8'h0);
    chk("mid_upd_so", 8'(so), 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
